adder_n: RTL and testbench
==========================

Name: adder_n

Overview:
- Parameterised N-bit binary adder: sum = a + b + c_in, with carry-out.
- Building block for ALU and datapath arithmetic.
- The primary sum/c_out path is purely combinational, with zero latency.
- A registered copy of the result is also provided for pipelined consumers, clocked by the single system clock with synchronous active-high reset.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock; clocks only the registered result copy.
- rst  input  1  synchronous, active-high reset; clears only the registered copy.
- a  input  N  operand A, unsigned (two's-complement operands work identically).
- b  input  N  operand B.
- c_in  input  1  carry-in, added at bit 0.
- sum  output  N  combinational result, (a + b + c_in) mod 2^N.
- c_out  output  1  combinational carry-out of bit N-1.
- sum_q  output  N  sum registered on the rising clk edge.
- c_out_q  output  1  c_out registered on the rising clk edge.

Behaviour:
- Combinational path:
  - {c_out, sum} equals the (N+1)-bit value of a + b + c_in, exactly.
  - Valid within the same delta/settling time as the input change; no clock is required.
  - Independent of clk and rst: it stays correct during and after reset, and before any clock edge.
- Structure: ripple-carry.
  - carry[0] = c_in.
  - For each bit i: sum[i] = a[i] ^ b[i] ^ carry[i]; carry[i+1] = majority(a[i], b[i], carry[i]).
  - c_out = carry[N].
- Width rules:
  - The maximum possible total is 2^(N+1) - 1, so c_out alone captures all overflow.
  - There is no signed-overflow flag.
  - No X propagation beyond the standard operators: for all-known inputs, outputs must never be X or Z.
- Registered path, on each rising clk edge:
  - If rst is 1: sum_q <= 0 and c_out_q <= 0.
  - Else: sum_q <= sum and c_out_q <= c_out.
  - Latency is 1 cycle; there is no enable and no handshake.
- Reset values: sum_q = 0 and c_out_q = 0 after any clocked reset. sum and c_out have no reset value because they always track the inputs.
- Reset mid-operation: only the registered copy clears; the combinational outputs are unaffected.
- Wrap-around: all-ones + 1 gives sum = 0 and c_out = 1.
- N = 1 degenerates to a single full adder and must elaborate cleanly.

Decomposition:
- No shared package is needed; N is the only parameter and there are no typedefs.
- One sub-module, full_adder (inputs a, b, c_in; outputs sum, c_out), instantiated N times via a generate loop with an internal carry[N:0] chain.
- The result register is a single always_ff in adder_n.

Test Plan (N = 8 unless stated; combinational outputs checked 1 time unit after stimulus with 4-state !==; registered outputs checked after a clock edge):
- Zero: a=0, b=0, c_in=0 -> sum=0, c_out=0. Next edge with rst=0 -> sum_q=0, c_out_q=0.
- Small: a=2, b=2, c_in=0 -> sum=4, c_out=0.
- Wrap: a=8'hFF, b=1, c_in=0 -> sum=0, c_out=1.
- Carry-in overflow: a=8'h7F, b=8'h80, c_in=1 -> sum=0, c_out=1. Also a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
- Register and reset:
  - Hold a=5, b=3, c_in=1 with rst=1 for one edge -> sum_q=0, c_out_q=0, while sum=9.
  - Deassert rst -> next edge sum_q=9, c_out_q=0.
  - Assert rst mid-stream -> sum_q clears on the following edge only.
- Random: at least 1000 random {a, b, c_in} vectors, also run at N=1 and N=32; each vector must satisfy {c_out, sum} == a + b + c_in (computed at N+1 bits). The error count must be 0.

Source files
------------

// File: rtl/full_adder.sv
// One-bit full adder cell, the ripple stage of adder_n.
// Latency: combinational, zero cycles.
// Backpressure: none; the cell always reflects its inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    // Sum is the parity of the three inputs; carry is their majority.
    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder with carry-in/out, plus a registered copy of the result.
// Latency: sum/c_out combinational (zero cycles); sum_q/c_out_q one clk cycle later.
// Backpressure: none; no enable or handshake, the register loads every cycle.
module adder_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic [N-1:0] sum_q,
    output logic         c_out_q
);

    // carry[i] is the carry into bit i; carry[N] is the carry out of the top bit.
    logic [N:0]   carry;
    logic [N-1:0] sum_d;
    logic         c_out_d;

    assign carry[0] = c_in;

    // One full adder per bit, chained through the carry vector.
    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum_d[i]),
            .c_out (carry[i+1])
        );
    end

    // Combinational outputs are the chain itself; they never see clk or rst.
    always_comb begin
        c_out_d = carry[N];
        sum     = sum_d;
        c_out   = c_out_d;
    end

    // Registered result copy for pipelined consumers; reset clears only this copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

endmodule

// File: tb/tb_adder_n.sv
// Directed and random checks of adder_n at N = 8, 1 and 32.
// Combinational results are compared 1 time unit after each drive; registered
// results are pushed to per-width queues at drive time and popped after the edge.
module tb_adder_n;

    logic clk;
    logic rst;

    logic [7:0]  a8, b8, sum8, sum8_q;
    logic        c8, co8, co8_q;
    logic        a1, b1, sum1, sum1_q;
    logic        c1, co1, co1_q;
    logic [31:0] a32, b32, sum32, sum32_q;
    logic        c32, co32, co32_q;

    int n_vec;
    int n_err;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [32:0] q32[$];

    logic [8:0]  last8;
    logic [1:0]  last1;
    logic [32:0] last32;
    bit          have_last;

    adder_n #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(c8),
        .sum(sum8), .c_out(co8), .sum_q(sum8_q), .c_out_q(co8_q)
    );

    adder_n #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c1),
        .sum(sum1), .c_out(co1), .sum_q(sum1_q), .c_out_q(co1_q)
    );

    adder_n #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .c_in(c32),
        .sum(sum32), .c_out(co32), .sum_q(sum32_q), .c_out_q(co32_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one vector to all three adders, check the combinational result,
    // check the register still holds the previous value, then clock and check it.
    task automatic step(input string tag,
                        input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                        input logic ia1, input logic ib1, input logic ic1,
                        input logic [31:0] ia32, input logic [31:0] ib32, input logic ic32,
                        input logic irst);
        logic [8:0]  e8;
        logic [1:0]  e1;
        logic [32:0] e32;
        a8 = ia8;   b8 = ib8;   c8 = ic8;
        a1 = ia1;   b1 = ib1;   c1 = ic1;
        a32 = ia32; b32 = ib32; c32 = ic32;
        rst = irst;
        e8  = {1'b0, ia8} + {1'b0, ib8} + {8'd0, ic8};
        e1  = {1'b0, ia1} + {1'b0, ib1} + {1'b0, ic1};
        e32 = {1'b0, ia32} + {1'b0, ib32} + {32'd0, ic32};
        #1;
        chk({tag, "/comb8"},  {55'd0, co8, sum8},   {55'd0, e8});
        chk({tag, "/comb1"},  {62'd0, co1, sum1},   {62'd0, e1});
        chk({tag, "/comb32"}, {31'd0, co32, sum32}, {31'd0, e32});
        if (have_last) begin
            chk({tag, "/hold8"},  {55'd0, co8_q, sum8_q},   {55'd0, last8});
            chk({tag, "/hold32"}, {31'd0, co32_q, sum32_q}, {31'd0, last32});
        end
        q8.push_back(irst ? 9'd0 : e8);
        q1.push_back(irst ? 2'd0 : e1);
        q32.push_back(irst ? 33'd0 : e32);
        @(posedge clk);
        #1;
        last8  = q8.pop_front();
        last1  = q1.pop_front();
        last32 = q32.pop_front();
        have_last = 1'b1;
        chk({tag, "/reg8"},  {55'd0, co8_q, sum8_q},   {55'd0, last8});
        chk({tag, "/reg1"},  {62'd0, co1_q, sum1_q},   {62'd0, last1});
        chk({tag, "/reg32"}, {31'd0, co32_q, sum32_q}, {31'd0, last32});
        // Combinational outputs must not be disturbed by the edge or by reset.
        chk({tag, "/post8"}, {55'd0, co8, sum8}, {55'd0, e8});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        have_last = 1'b0;
        rst = 1'b1;

        // Reset while inputs are nonzero: register clears, comb path still adds.
        step("rst_hold", 8'd5, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1,
             32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        step("rst_rel", 8'd5, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0,
             32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        step("zero", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'd0, 32'd0, 1'b0, 1'b0);
        step("small", 8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1,
             32'd2, 32'd2, 1'b0, 1'b0);
        step("wrap", 8'hFF, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1,
             32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step("cin_ovf", 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1,
             32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        step("all_ones", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step("load9", 8'd5, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0,
             32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
        // Mid-stream reset: the hold check inside step confirms the register
        // keeps its old value until the edge that samples rst.
        step("rst_mid", 8'hA5, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0,
             32'hCAFE_F00D, 32'h3501_0FF3, 1'b1, 1'b1);
        step("after_rst", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1,
             32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 1200; i++) begin
            step("rand",
                 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, $urandom, 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
